dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL provide parameter AW, default 8, word-address width; the memory holds 2^AW 32-bit words.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2, wait states between request acceptance and response (0..15).
REQ-003 SHALL provide port CLK, input, 1, rising-edge clock for all state.
REQ-004 SHALL provide port RESET, input, 1; one clock, reset synchronous and active-high.
REQ-005 SHALL provide port req_valid, input, 1, CPU request present.
REQ-006 SHALL provide port req_ready, output, 1, responder can accept a request.
REQ-007 SHALL provide port req_we, input, 1, 1=store, 0=load.
REQ-008 SHALL provide port req_addr, input, 32, byte address.
REQ-009 SHALL provide port req_wdata, input, 32, store data.
REQ-010 SHALL provide port req_be, input, 4, store byte enables; bit i gates byte lane [8i+7:8i].
REQ-011 SHALL provide port rsp_valid, output, 1, response present.
REQ-012 SHALL provide port rsp_ready, input, 1, CPU accepts response.
REQ-013 SHALL provide port rsp_rdata, output, 32, full aligned load word (0 for stores and errors).
REQ-014 SHALL provide port rsp_err, output, 1, address out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid&&req_ready.
REQ-017 SHALL latch req_we, req_addr, req_wdata, req_be at acceptance; later input changes have no effect.
REQ-018 SHALL transition IDLE->WAIT on acceptance when WAIT_CYCLES>0, else IDLE->RESP.
REQ-019 SHALL count WAIT_CYCLES cycles in WAIT with a down-counter loaded at acceptance, then enter RESP.
REQ-020 SHALL assert rsp_valid exactly from cycle N+1+WAIT_CYCLES when accepted at edge N, and only in RESP.
REQ-021 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1; that edge returns to IDLE.
REQ-022 SHALL not accept a new request on the RESP->IDLE edge (req_ready low in RESP); back-to-back issue rate is one per 2+WAIT_CYCLES cycles.
REQ-023 SHALL index memory by req_addr[AW+1:2], ignoring req_addr[1:0]; sub-word alignment is the CPU's job via req_be.
REQ-024 SHALL flag rsp_err=1 when req_addr[31:AW+2] is nonzero; such stores do not modify memory and such loads return 0.
REQ-025 SHALL perform a store on the edge entering RESP, updating only lanes with req_be=1; req_be=0000 is a legal no-op store with normal response.
REQ-026 SHALL capture load data on the edge entering RESP, so a load after a store to the same word returns the stored bytes.
REQ-027 SHALL ignore req_be for loads.

Reset
REQ-028 SHALL on RESET force IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 from the next cycle.
REQ-029 SHALL abort any in-flight request on RESET, including in WAIT, with no memory write and no response.
REQ-030 SHALL not clear memory contents on RESET.

Verification
REQ-031 SHALL test store 0xDEADBEEF, be=1111, addr 0x10, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at acceptance+3 cycles (WAIT_CYCLES=2).
REQ-032 SHALL test store 0x000000AA be=0001 then 0x0000BB00 be=0010 to addr 0x12 over 0x11223344 -> load returns 0x1122BBAA.
REQ-033 SHALL test load addr 0x00001000 (AW=8) -> rsp_err=1, rsp_rdata=0; store there leaves word 0 unchanged.
REQ-034 SHALL test rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-035 SHALL test RESET asserted in WAIT during store 0x55555555 to 0x20 -> no response, subsequent load 0x20 returns previous contents.
REQ-036 SHALL test WAIT_CYCLES=0 -> rsp_valid on cycle immediately after acceptance.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready request/response pair.
// A request is latched in IDLE, optionally waits WAIT_CYCLES, then is answered from RESP.
module dmem_responder #(
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request transfers on an edge with req_valid && req_ready, a
    // response on an edge with rsp_valid && rsp_ready; both sides hold until then.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    state_t        r_state;
    state_t        w_next_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [2**AW];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // With no wait states the access happens on the acceptance edge itself,
    // so the live request fields are used instead of the latched copies.
    assign w_we    = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_be    = (r_state == ST_IDLE) ? req_be    : r_be;
    assign w_err   = |w_addr[31:AW+2];
    assign w_idx   = w_addr[AW+1:2];

    always_comb begin
        w_next_state = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LP_WAIT == 4'd0) begin
                        w_next_state = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= LP_WAIT;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
                r_err   <= w_err;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Memory is deliberately left out of reset; an aborted access never writes.
    always_ff @(posedge CLK) begin
        if (!RESET && w_enter_resp && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against a word-array model;
// a second instance covers the zero-wait-state configuration.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  dbg_state;

    logic        req_valid_z, req_we_z, rsp_ready_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic [3:0]  req_be_z;
    logic        req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;
    logic [1:0]  dbg_state_z;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [256];

    always #5 clk = ~clk;

    dmem_responder #(.AW(8), .WAIT_CYCLES(2)) dut (
        .CLK(clk), .RESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .o_dbg_state(dbg_state)
    );

    dmem_responder #(.AW(8), .WAIT_CYCLES(0)) dut0 (
        .CLK(clk), .RESET(rst),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
        .rsp_err(rsp_err_z), .o_dbg_state(dbg_state_z)
    );

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [31:0] a);
        return (a >= 32'h400);
    endfunction

    function automatic logic [31:0] model_load(input logic we, input logic [31:0] a);
        if (we || model_err(a)) return 32'd0;
        return model_mem[a / 4 % 256];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        if (model_err(a)) return;
        w = model_mem[a / 4 % 256];
        for (int i = 0; i < 4; i++)
            if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        model_mem[a / 4 % 256] = w;
    endtask

    // ---------------- driver ----------------
    // Returns first-response latency in cycles after acceptance (-1 on timeout),
    // response fields, whether they held steady while stalled, and whether the
    // block was idle one cycle after the response handshake.
    task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int hold,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic stable, output logic idle_ok);
        int wt;
        lat = -1; rd = 'x; er = 'x; stable = 1'b0; idle_ok = 1'b0;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        wt = 0;
        while (req_ready !== 1'b1 && wt < 20) begin @(negedge clk); wt++; end
        if (wt >= 20) begin req_valid = 1'b0; return; end
        @(negedge clk);
        req_valid = 1'b0;
        req_we = $urandom; req_addr = $urandom; req_wdata = $urandom; req_be = $urandom;
        wt = 1;
        while (rsp_valid !== 1'b1 && wt < 40) begin @(negedge clk); wt++; end
        if (wt >= 40) return;
        lat = wt; rd = rsp_rdata; er = rsp_err;
        stable = (req_ready === 1'b0);
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        idle_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0", req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        n_vec++;
        if (req_ready_z !== 1'b1 || rsp_valid_z !== 1'b0 || rsp_rdata_z !== 32'd0 || rsp_err_z !== 1'b0) begin
            n_err++;
            $display("FAIL reset_w0: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0", req_ready_z, rsp_valid_z, rsp_rdata_z, rsp_err_z);
        end
        rst = 1'b0;
    endtask

    task automatic fill_mem;
        int lat; logic [31:0] rd, d; logic er, st, id;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            do_txn(1'b1, 32'(i * 4), d, 4'hF, 0, lat, rd, er, st, id);
            model_store(32'(i * 4), d, 4'hF);
        end
    endtask

    task automatic test_store_load;
        int lat; logic [31:0] rd; logic er, st, id;
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, lat, rd, er, st, id);
        model_store(32'h10, 32'hDEADBEEF, 4'hF);
        n_vec++;
        if (lat !== 3 || rd !== 32'd0 || er !== 1'b0 || !id) begin
            n_err++;
            $display("FAIL store_0x10: lat=%0d rdata=%h err=%b idle=%b, want 3 0 0 1", lat, rd, er, id);
        end
        do_txn(1'b0, 32'h10, $urandom, $urandom, 0, lat, rd, er, st, id);
        n_vec++;
        if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0 || !id) begin
            n_err++;
            $display("FAIL load_0x10: lat=%0d rdata=%h err=%b idle=%b, want 3 deadbeef 0 1", lat, rd, er, id);
        end
    endtask

    task automatic test_byte_lanes;
        int lat; logic [31:0] rd; logic er, st, id;
        do_txn(1'b1, 32'h12, 32'h11223344, 4'hF, 0, lat, rd, er, st, id);
        model_store(32'h12, 32'h11223344, 4'hF);
        do_txn(1'b1, 32'h12, 32'h000000AA, 4'b0001, 0, lat, rd, er, st, id);
        model_store(32'h12, 32'h000000AA, 4'b0001);
        do_txn(1'b1, 32'h12, 32'h0000BB00, 4'b0010, 0, lat, rd, er, st, id);
        model_store(32'h12, 32'h0000BB00, 4'b0010);
        do_txn(1'b0, 32'h12, 32'h0, 4'h0, 0, lat, rd, er, st, id);
        n_vec++;
        if (rd !== 32'h1122BBAA || er !== 1'b0) begin
            n_err++;
            $display("FAIL byte_lanes: rdata=%h err=%b, want 1122bbaa 0", rd, er);
        end
        do_txn(1'b1, 32'h12, 32'hFFFFFFFF, 4'b0000, 0, lat, rd, er, st, id);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er, st, id);
        n_vec++;
        if (rd !== 32'h1122BBAA || lat !== 3) begin
            n_err++;
            $display("FAIL be_zero_noop: rdata=%h lat=%0d, want 1122bbaa 3", rd, lat);
        end
    endtask

    task automatic test_error;
        int lat; logic [31:0] rd, w0; logic er, st, id;
        do_txn(1'b0, 32'h00001000, 32'h0, 4'hF, 0, lat, rd, er, st, id);
        n_vec++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) begin
            n_err++;
            $display("FAIL err_load: err=%b rdata=%h lat=%0d, want 1 0 3", er, rd, lat);
        end
        w0 = model_mem[0];
        do_txn(1'b1, 32'h00001000, ~w0, 4'hF, 0, lat, rd, er, st, id);
        n_vec++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_err++;
            $display("FAIL err_store: err=%b rdata=%h, want 1 0", er, rd);
        end
        do_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, lat, rd, er, st, id);
        n_vec++;
        if (rd !== w0 || er !== 1'b0) begin
            n_err++;
            $display("FAIL err_word0: rdata=%h err=%b, want %h 0", rd, er, w0);
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] rd; logic er, st, id;
        do_txn(1'b0, 32'h44, 32'h0, 4'h0, 5, lat, rd, er, st, id);
        n_vec++;
        if (!st || !id || rd !== model_mem[8'h11] || lat !== 3) begin
            n_err++;
            $display("FAIL backpressure: stable=%b idle=%b rdata=%h lat=%0d, want 1 1 %h 3", st, id, rd, lat, model_mem[8'h11]);
        end
    endtask

    task automatic test_reset_in_wait;
        int lat, seen; logic [31:0] rd, prev; logic er, st, id;
        prev = model_mem[8];
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55555555; req_be = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++;
        if (dbg_state !== 2'd1) begin
            n_err++;
            $display("FAIL wait_state: state=%0d, want 1", dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
            @(negedge clk);
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_no_rsp: busy_cycles=%0d, want 0", seen);
        end
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, lat, rd, er, st, id);
        n_vec++;
        if (rd !== prev || er !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_write: rdata=%h err=%b, want %h 0", rd, er, prev);
        end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (req_ready === 1'b1) acc.push_back(c);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++;
        if (acc.size() != 5) begin
            n_err++;
            $display("FAIL b2b_count: accepts=%0d, want 5", acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            n_vec++;
            if (acc[i] - acc[i-1] != 4) begin
                n_err++;
                $display("FAIL b2b_spacing: gap=%0d, want 4", acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_random;
        int lat, hold; logic [31:0] rd, a, d, exp_rd; logic [3:0] be; logic we, er, st, id, exp_er;
        for (int t = 0; t < 40; t++) begin
            we = $urandom_range(0, 1);
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & 32'h3FF;
            else if (a < 32'h400) a = a | 32'h400;
            d = $urandom; be = $urandom; hold = $urandom_range(0, 3);
            exp_q.push_back(model_load(we, a));
            exp_er = model_err(a);
            if (we) model_store(a, d, be);
            do_txn(we, a, d, be, hold, lat, rd, er, st, id);
            exp_rd = exp_q.pop_front();
            n_vec++;
            if (rd !== exp_rd || er !== exp_er || lat !== 3 || !st || !id) begin
                n_err++;
                $display("FAIL random[%0d] we=%b a=%h: rdata=%h err=%b lat=%0d st=%b idle=%b, want %h %b 3 1 1",
                         t, we, a, rd, er, lat, st, id, exp_rd, exp_er);
            end
        end
    endtask

    task automatic test_wait0;
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        req_we_z = 1'b1; req_addr_z = 32'h84; req_wdata_z = d; req_be_z = 4'hF; req_valid_z = 1'b1;
        @(negedge clk);
        req_valid_z = 1'b0; req_wdata_z = ~d;
        n_vec++;
        if (rsp_valid_z !== 1'b1 || rsp_rdata_z !== 32'd0 || rsp_err_z !== 1'b0) begin
            n_err++;
            $display("FAIL w0_store: valid=%b rdata=%h err=%b, want 1 0 0", rsp_valid_z, rsp_rdata_z, rsp_err_z);
        end
        rsp_ready_z = 1'b1;
        @(negedge clk);
        rsp_ready_z = 1'b0;
        req_we_z = 1'b0; req_valid_z = 1'b1;
        @(negedge clk);
        req_valid_z = 1'b0;
        n_vec++;
        if (rsp_valid_z !== 1'b1 || rsp_rdata_z !== d || rsp_err_z !== 1'b0) begin
            n_err++;
            $display("FAIL w0_load: valid=%b rdata=%h err=%b, want 1 %h 0", rsp_valid_z, rsp_rdata_z, rsp_err_z, d);
        end
        rsp_ready_z = 1'b1;
        @(negedge clk);
        rsp_ready_z = 1'b0;
        n_vec++;
        if (rsp_valid_z !== 1'b0 || req_ready_z !== 1'b1) begin
            n_err++;
            $display("FAIL w0_idle: valid=%b ready=%b, want 0 1", rsp_valid_z, req_ready_z);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0; rsp_ready_z = 1'b0;
        test_reset();
        fill_mem();
        test_store_load();
        test_byte_lanes();
        test_error();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        test_wait0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
